aemb2_fetch: RTL and testbench

Instruction-fetch stage of the AEMB2 pipeline, directly upstream of the decode/operand-fetch control stage.
- Holds one program counter per hardware thread.
- Drives a Wishbone-style instruction bus and presents the fetched word (ich_dat) and its word address (rpc_if) to decode.
- Redirects on EX-stage branches, holds on forwarding hazards, and generates the thread phase gpha.

---
 rtl/aemb2_pkg.sv | 14 +
 rtl/aemb2_fetch_if.sv | 25 ++
 rtl/aemb2_fetch_pc.sv | 35 +++
 rtl/aemb2_fetch.sv | 102 ++++++++++
 tb/tb_aemb2_fetch.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/aemb2_pkg.sv
// Shared AEMB2 fetch definitions: FSM encodings, fixed opcodes and bra_ex bit names.
package aemb2_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP = 32'h88000000;
  localparam logic [31:0] XCE = 32'hBA2D0020;  // branch to exception vector 0x20

  localparam int BRA_TAKEN = 1;
  localparam int BRA_DSLOT = 0;
endpackage

// File: rtl/aemb2_fetch_if.sv
// Fetch-stage bundle: instruction bus on one side, decode hand-off on the other.
interface aemb2_fetch_if #(parameter int AEMB_IWB = 32);
  logic [AEMB_IWB-3:0] iwb_adr_o;
  logic                iwb_stb_o;
  logic                iwb_ack_i;
  logic [31:0]         iwb_dat_i;
  logic [31:0]         ich_dat;
  logic [29:0]         rpc_if;
  logic                iena;
  logic                dena;
  logic                gpha;
  logic [1:0]          bra_ex;
  logic [29:0]         bpc_ex;
  logic                hzd_fwd;

  modport master (
    output iwb_adr_o, iwb_stb_o, ich_dat, rpc_if, iena, gpha,
    input  iwb_ack_i, iwb_dat_i, dena, bra_ex, bpc_ex, hzd_fwd
  );

  modport slave (
    input  iwb_adr_o, iwb_stb_o, ich_dat, rpc_if, iena, gpha,
    output iwb_ack_i, iwb_dat_i, dena, bra_ex, bpc_ex, hzd_fwd
  );
endinterface

// File: rtl/aemb2_fetch_pc.sv
// Per-thread program counters with redirect/increment mux.
// pc_nxt is the address of the request that follows an advance, bypassing the write when the thread repeats.
module aemb2_fetch_pc #(
  parameter int AEMB_HTX = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        sel,
  input  logic        taken,
  input  logic [29:0] bpc,
  input  logic [29:0] rpc,
  output logic [29:0] pc_cur,
  output logic [29:0] pc_nxt,
  output logic        pha_nxt
);
  logic [29:0] pc0;
  logic [29:0] pc1;
  logic [29:0] wr_pc;

  assign wr_pc   = taken ? bpc : rpc + 30'd1;
  assign pha_nxt = (AEMB_HTX != 0) ? ~sel : 1'b0;
  assign pc_cur  = sel ? pc1 : pc0;
  assign pc_nxt  = (pha_nxt == sel) ? wr_pc : (pha_nxt ? pc1 : pc0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc0 <= '0;
      pc1 <= '0;
    end else if (wr_en) begin
      if (sel) pc1 <= wr_pc;
      else     pc0 <= wr_pc;
    end
  end
endmodule

// File: rtl/aemb2_fetch.sv
// AEMB2 instruction fetch: one PC per hardware thread, Wishbone-style instruction bus, hands words to decode.
// Optional ack timeout with exception injection under AEMB2_FETCH_TMO_EN.
module aemb2_fetch
  import aemb2_pkg::*;
#(
  parameter int AEMB_HTX = 1,
  parameter int AEMB_IWB = 32,
  parameter int AEMB_TMO = 8
) (
  input logic            gclk,
  input logic            grst,
  aemb2_fetch_if.master  fif
);
  localparam int AW = AEMB_IWB - 2;

  fetch_state_t state;
  logic         advance;
  logic [29:0]  pc_cur;
  logic [29:0]  pc_nxt;
  logic         pha_nxt;
  logic         unused_dslot;

  // Delay-slot handling belongs to decode; fetch only follows the taken bit.
  assign unused_dslot = fif.bra_ex[BRA_DSLOT];
  assign advance      = (state == ST_VALID) && fif.dena && !fif.hzd_fwd;

  aemb2_fetch_pc #(.AEMB_HTX(AEMB_HTX)) u_pc (
    .clk     (gclk),
    .rst     (grst),
    .wr_en   (advance),
    .sel     (fif.gpha),
    .taken   (fif.bra_ex[BRA_TAKEN]),
    .bpc     (fif.bpc_ex),
    .rpc     (fif.rpc_if),
    .pc_cur  (pc_cur),
    .pc_nxt  (pc_nxt),
    .pha_nxt (pha_nxt)
  );

`ifdef AEMB2_FETCH_TMO_EN
  logic [AEMB_TMO-1:0] tmo_cnt;
`endif

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      state         <= ST_IDLE;
      fif.iwb_stb_o <= 1'b0;
      fif.iwb_adr_o <= '0;
      fif.ich_dat   <= NOP;
      fif.rpc_if    <= '0;
      fif.iena      <= 1'b0;
      fif.gpha      <= 1'b0;
`ifdef AEMB2_FETCH_TMO_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          state         <= ST_REQ;
          fif.iwb_stb_o <= 1'b1;
          fif.iwb_adr_o <= AW'(pc_cur);
`ifdef AEMB2_FETCH_TMO_EN
          tmo_cnt       <= '0;
`endif
        end
        ST_REQ: begin
          if (fif.iwb_ack_i) begin
            state         <= ST_VALID;
            fif.iwb_stb_o <= 1'b0;
            fif.ich_dat   <= fif.iwb_dat_i;
            fif.rpc_if    <= 30'(fif.iwb_adr_o);
            fif.iena      <= 1'b1;
`ifdef AEMB2_FETCH_TMO_EN
          end else if (&tmo_cnt) begin
            // Dead bus: abandon the cycle and trap via the exception vector.
            state         <= ST_VALID;
            fif.iwb_stb_o <= 1'b0;
            fif.ich_dat   <= XCE;
            fif.rpc_if    <= 30'(fif.iwb_adr_o);
            fif.iena      <= 1'b1;
          end else begin
            tmo_cnt       <= tmo_cnt + 1'b1;
`endif
          end
        end
        ST_VALID: begin
          if (advance) begin
            state         <= ST_REQ;
            fif.iena      <= 1'b0;
            fif.gpha      <= pha_nxt;
            fif.iwb_stb_o <= 1'b1;
            fif.iwb_adr_o <= AW'(pc_nxt);
`ifdef AEMB2_FETCH_TMO_EN
            tmo_cnt       <= '0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aemb2_fetch.sv
// Bench: single-thread and two-thread fetch units driven in lockstep from one directed vector table.
module tb_aemb2_fetch;
  import aemb2_pkg::*;

  logic        gclk;
  logic        grst;
  logic        ack;
  logic [31:0] dat;
  logic        dena;
  logic [1:0]  bra;
  logic [29:0] bpc;
  logic        hzd;

  int checks = 0;
  int errors = 0;

  aemb2_fetch_if #(.AEMB_IWB(32)) if0 ();
  aemb2_fetch_if #(.AEMB_IWB(32)) if1 ();

  assign if0.iwb_ack_i = ack;  assign if1.iwb_ack_i = ack;
  assign if0.iwb_dat_i = dat;  assign if1.iwb_dat_i = dat;
  assign if0.dena      = dena; assign if1.dena      = dena;
  assign if0.bra_ex    = bra;  assign if1.bra_ex    = bra;
  assign if0.bpc_ex    = bpc;  assign if1.bpc_ex    = bpc;
  assign if0.hzd_fwd   = hzd;  assign if1.hzd_fwd   = hzd;

  aemb2_fetch #(.AEMB_HTX(0), .AEMB_IWB(32), .AEMB_TMO(8)) u0 (
    .gclk (gclk), .grst (grst), .fif (if0)
  );
  aemb2_fetch #(.AEMB_HTX(1), .AEMB_IWB(32), .AEMB_TMO(4)) u1 (
    .gclk (gclk), .grst (grst), .fif (if1)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  typedef struct {
    logic        ack;
    logic [31:0] dat;
    logic        dena;
    logic [1:0]  bra;
    logic [29:0] bpc;
    logic        hzd;
    logic        e_stb;
    logic [29:0] e_adr0;
    logic [29:0] e_adr1;
    logic        e_iena;
    logic [31:0] e_ich;
    logic [29:0] e_rpc0;
    logic [29:0] e_rpc1;
    logic        e_gpha1;
  } vec_t;

  vec_t vt[28];

  function automatic vec_t mk(
    input logic a, input logic [31:0] d, input logic de, input logic [1:0] b,
    input logic [29:0] bp, input logic hz, input logic stb, input logic [29:0] a0,
    input logic [29:0] a1, input logic ie, input logic [31:0] ich,
    input logic [29:0] r0, input logic [29:0] r1, input logic g1);
    vec_t v;
    v.ack = a; v.dat = d; v.dena = de; v.bra = b; v.bpc = bp; v.hzd = hz;
    v.e_stb = stb; v.e_adr0 = a0; v.e_adr1 = a1; v.e_iena = ie; v.e_ich = ich;
    v.e_rpc0 = r0; v.e_rpc1 = r1; v.e_gpha1 = g1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " stb0"},  32'(if0.iwb_stb_o), 32'h0);
    chk({tag, " stb1"},  32'(if1.iwb_stb_o), 32'h0);
    chk({tag, " adr0"},  32'(if0.iwb_adr_o), 32'h0);
    chk({tag, " adr1"},  32'(if1.iwb_adr_o), 32'h0);
    chk({tag, " ich0"},  if0.ich_dat, NOP);
    chk({tag, " ich1"},  if1.ich_dat, NOP);
    chk({tag, " rpc0"},  32'(if0.rpc_if), 32'h0);
    chk({tag, " rpc1"},  32'(if1.rpc_if), 32'h0);
    chk({tag, " iena0"}, 32'(if0.iena), 32'h0);
    chk({tag, " iena1"}, 32'(if1.iena), 32'h0);
    chk({tag, " gpha1"}, 32'(if1.gpha), 32'h0);
  endtask

  // Decode must never be told to advance on an invalid word.
  always @(negedge gclk) begin
    if (!grst && dena && !if1.iena) begin
      errors++;
      $display("FAIL dena_without_iena got dena=1 iena=0 want iena=1");
    end
  end

  initial begin
    grst = 1'b1; ack = 1'b0; dat = '0; dena = 1'b0; bra = 2'b00; bpc = '0; hzd = 1'b0;

    //       ack dat           dena bra    bpc          hzd | stb adr0         adr1         iena ich           rpc0         rpc1         g1
    vt[0]  = mk(0, 32'h0,        0, 2'b00, 30'h0,        0,   1, 30'h0,       30'h0,       0,   NOP,          30'h0,       30'h0,       0);
    vt[1]  = mk(0, 32'h0,        0, 2'b00, 30'h0,        0,   1, 30'h0,       30'h0,       0,   NOP,          30'h0,       30'h0,       0);
    vt[2]  = mk(1, 32'h30200005, 0, 2'b00, 30'h0,        0,   0, 30'h0,       30'h0,       1,   32'h30200005, 30'h0,       30'h0,       0);
    vt[3]  = mk(0, 32'h0,        1, 2'b00, 30'h0,        0,   1, 30'h1,       30'h0,       0,   32'h30200005, 30'h0,       30'h0,       1);
    vt[4]  = mk(1, 32'h11111111, 0, 2'b00, 30'h0,        0,   0, 30'h1,       30'h0,       1,   32'h11111111, 30'h1,       30'h0,       1);
    vt[5]  = mk(0, 32'h0,        1, 2'b00, 30'h0,        0,   1, 30'h2,       30'h1,       0,   32'h11111111, 30'h1,       30'h0,       0);
    vt[6]  = mk(1, 32'h22222222, 0, 2'b00, 30'h0,        0,   0, 30'h2,       30'h1,       1,   32'h22222222, 30'h2,       30'h1,       0);
    vt[7]  = mk(0, 32'h0,        1, 2'b00, 30'h0,        0,   1, 30'h3,       30'h1,       0,   32'h22222222, 30'h2,       30'h1,       1);
    vt[8]  = mk(1, 32'h33333333, 0, 2'b00, 30'h0,        0,   0, 30'h3,       30'h1,       1,   32'h33333333, 30'h3,       30'h1,       1);
    vt[9]  = mk(0, 32'h0,        1, 2'b00, 30'h0,        0,   1, 30'h4,       30'h2,       0,   32'h33333333, 30'h3,       30'h1,       0);
    vt[10] = mk(1, 32'h44444444, 0, 2'b00, 30'h0,        0,   0, 30'h4,       30'h2,       1,   32'h44444444, 30'h4,       30'h2,       0);
    vt[11] = mk(0, 32'h0,        1, 2'b10, 30'h10,       0,   1, 30'h10,      30'h2,       0,   32'h44444444, 30'h4,       30'h2,       1);
    vt[12] = mk(1, 32'h55555555, 0, 2'b00, 30'h0,        0,   0, 30'h10,      30'h2,       1,   32'h55555555, 30'h10,      30'h2,       1);
    vt[13] = mk(0, 32'h0,        1, 2'b11, 30'h100,      0,   1, 30'h100,     30'h10,      0,   32'h55555555, 30'h10,      30'h2,       0);
    vt[14] = mk(1, 32'h66666666, 0, 2'b00, 30'h0,        0,   0, 30'h100,     30'h10,      1,   32'h66666666, 30'h100,     30'h10,      0);
    vt[15] = mk(0, 32'h0,        1, 2'b10, 30'h100,      0,   1, 30'h100,     30'h100,     0,   32'h66666666, 30'h100,     30'h10,      1);
    vt[16] = mk(1, 32'h77777777, 0, 2'b00, 30'h0,        0,   0, 30'h100,     30'h100,     1,   32'h77777777, 30'h100,     30'h100,     1);
    vt[17] = mk(0, 32'h0,        1, 2'b10, 30'h200,      1,   0, 30'h100,     30'h100,     1,   32'h77777777, 30'h100,     30'h100,     1);
    vt[18] = mk(0, 32'h0,        1, 2'b10, 30'h200,      1,   0, 30'h100,     30'h100,     1,   32'h77777777, 30'h100,     30'h100,     1);
    vt[19] = mk(0, 32'h0,        1, 2'b10, 30'h200,      1,   0, 30'h100,     30'h100,     1,   32'h77777777, 30'h100,     30'h100,     1);
    vt[20] = mk(0, 32'h0,        1, 2'b00, 30'h0,        0,   1, 30'h101,     30'h100,     0,   32'h77777777, 30'h100,     30'h100,     0);
    vt[21] = mk(1, 32'h12345678, 0, 2'b00, 30'h0,        0,   0, 30'h101,     30'h100,     1,   32'h12345678, 30'h101,     30'h100,     0);
    vt[22] = mk(0, 32'h0,        1, 2'b10, 30'h3FFFFFFF, 0,   1, 30'h3FFFFFFF, 30'h101,    0,   32'h12345678, 30'h101,     30'h100,     1);
    vt[23] = mk(1, 32'h9ABCDEF0, 0, 2'b00, 30'h0,        0,   0, 30'h3FFFFFFF, 30'h101,    1,   32'h9ABCDEF0, 30'h3FFFFFFF, 30'h101,    1);
    vt[24] = mk(0, 32'h0,        1, 2'b00, 30'h0,        0,   1, 30'h0,       30'h3FFFFFFF, 0,  32'h9ABCDEF0, 30'h3FFFFFFF, 30'h101,    0);
    vt[25] = mk(1, 32'h0F0F0F0F, 0, 2'b00, 30'h0,        0,   0, 30'h0,       30'h3FFFFFFF, 1,  32'h0F0F0F0F, 30'h0,       30'h3FFFFFFF, 0);
    vt[26] = mk(0, 32'h0,        1, 2'b00, 30'h0,        0,   1, 30'h1,       30'h102,     0,   32'h0F0F0F0F, 30'h0,       30'h3FFFFFFF, 1);
    vt[27] = mk(0, 32'h0,        0, 2'b00, 30'h0,        0,   1, 30'h1,       30'h102,     0,   32'h0F0F0F0F, 30'h0,       30'h3FFFFFFF, 1);

    repeat (2) @(posedge gclk);
    #1;
    chk_reset("reset");
    grst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      ack = vt[i].ack; dat = vt[i].dat; dena = vt[i].dena;
      bra = vt[i].bra; bpc = vt[i].bpc; hzd = vt[i].hzd;
      @(posedge gclk);
      #1;
      chk($sformatf("v%0d stb0", i),  32'(if0.iwb_stb_o), 32'(vt[i].e_stb));
      chk($sformatf("v%0d stb1", i),  32'(if1.iwb_stb_o), 32'(vt[i].e_stb));
      chk($sformatf("v%0d adr0", i),  32'(if0.iwb_adr_o), 32'(vt[i].e_adr0));
      chk($sformatf("v%0d adr1", i),  32'(if1.iwb_adr_o), 32'(vt[i].e_adr1));
      chk($sformatf("v%0d iena0", i), 32'(if0.iena),      32'(vt[i].e_iena));
      chk($sformatf("v%0d iena1", i), 32'(if1.iena),      32'(vt[i].e_iena));
      chk($sformatf("v%0d ich0", i),  if0.ich_dat,        vt[i].e_ich);
      chk($sformatf("v%0d ich1", i),  if1.ich_dat,        vt[i].e_ich);
      chk($sformatf("v%0d rpc0", i),  32'(if0.rpc_if),    32'(vt[i].e_rpc0));
      chk($sformatf("v%0d rpc1", i),  32'(if1.rpc_if),    32'(vt[i].e_rpc1));
      chk($sformatf("v%0d gpha0", i), 32'(if0.gpha),      32'h0);
      chk($sformatf("v%0d gpha1", i), 32'(if1.gpha),      32'(vt[i].e_gpha1));
    end

    // Asynchronous reset while a bus cycle is outstanding, followed by a stale ack.
    ack = 1'b0; dena = 1'b0; bra = 2'b00; bpc = '0; hzd = 1'b0;
    #2;
    grst = 1'b1;
    #1;
    chk_reset("async_rst");
    ack = 1'b1; dat = 32'hDEADBEEF;
    @(posedge gclk);
    #1;
    chk_reset("rst_held");
    grst = 1'b0;
    @(posedge gclk);
    #1;
    ack = 1'b0;
    chk("late_ack iena1", 32'(if1.iena),      32'h0);
    chk("late_ack stb0",  32'(if0.iwb_stb_o), 32'h1);
    chk("late_ack adr0",  32'(if0.iwb_adr_o), 32'h0);
    chk("late_ack adr1",  32'(if1.iwb_adr_o), 32'h0);
    chk("late_ack ich1",  if1.ich_dat,        NOP);

`ifdef AEMB2_FETCH_TMO_EN
    repeat (15) @(posedge gclk);
    #1;
    chk("tmo_pre iena1", 32'(if1.iena),      32'h0);
    chk("tmo_pre stb1",  32'(if1.iwb_stb_o), 32'h1);
    @(posedge gclk);
    #1;
    chk("tmo iena1", 32'(if1.iena),      32'h1);
    chk("tmo stb1",  32'(if1.iwb_stb_o), 32'h0);
    chk("tmo ich1",  if1.ich_dat,        XCE);
    chk("tmo rpc1",  32'(if1.rpc_if),    32'h0);
`else
    ack = 1'b1; dat = 32'h30200005;
    @(posedge gclk);
    #1;
    ack = 1'b0;
    chk("restart iena0", 32'(if0.iena),   32'h1);
    chk("restart iena1", 32'(if1.iena),   32'h1);
    chk("restart ich0",  if0.ich_dat,     32'h30200005);
    chk("restart rpc0",  32'(if0.rpc_if), 32'h0);
    chk("restart rpc1",  32'(if1.rpc_if), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
